// File: rtl/ps2_pad_responder.sv
// ps2_pad_responder: device end of a PS2 gamepad link; answers a master poll from an input snapshot.
// Latency: pin sclk fall -> sdo 3 clk; 8th sclk rise -> ack low 3+ACK_DELAY clk, held ACK_WIDTH clk.
// Flow control: the master paces bytes with ack; sclk edges outside SHIFT are ignored.
//
// Ports:
//   clk, rst        40 MHz system clock, asynchronous active-high reset
//   sclk, scs, sdi  link clock (idles high), attention (active low), command data (LSB first)
//   buttons         16 button bits, 1 = pressed; sent inverted
//   rx, ry, lx, ly  stick positions, 0x80 = centre
//   sdo, ack        reply data (LSB first, idles 1), acknowledge (active low, idles 1)
//   busy, polled    transaction in progress, one-clk pulse on a completed valid poll
`timescale 1ns/1ps

module ps2_pad_responder #(
  parameter bit ANALOG    = 1'b1,
  parameter int ACK_DELAY = 40,
  parameter int ACK_WIDTH = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        scs,
  input  logic        sdi,
  input  logic [15:0] buttons,
  input  logic [7:0]  rx,
  input  logic [7:0]  ry,
  input  logic [7:0]  lx,
  input  logic [7:0]  ly,
  output logic        sdo,
  output logic        ack,
  output logic        busy,
  output logic        polled
);

  // Frame shape depends on mode: analog carries the four stick bytes.
  localparam logic [7:0] PAD_ID    = ANALOG ? 8'h73 : 8'h41;
  localparam logic [3:0] LAST_BYTE = ANALOG ? 4'd8 : 4'd4;

  // One timer serves both the ack delay and the ack width phases.
  localparam int TMAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DELAY_END = TW'(ACK_DELAY - 1);
  localparam logic [TW-1:0] WIDTH_END = TW'(ACK_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACK_WAIT,
    ACK,
    HOLD
  } state_t;

  state_t        state;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [7:0]    cmd;
  logic [TW-1:0] timer;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. Bit [1] is the synced value, bit [2] its previous
  // sample, so edges are seen one cycle after the value is synced. sdi only
  // needs two stages: its synced bit lines up with the sclk rise detection.
  // Reset values match the idle levels of the link so reset never fakes an edge.
  // ---------------------------------------------------------------------------
  logic [2:0] sclk_sh;
  logic [2:0] scs_sh;
  logic [1:0] sdi_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sh <= 3'b111;
      scs_sh  <= 3'b111;
      sdi_sh  <= 2'b11;
    end else begin
      sclk_sh <= {sclk_sh[1:0], sclk};
      scs_sh  <= {scs_sh[1:0], scs};
      sdi_sh  <= {sdi_sh[0], sdi};
    end
  end

  logic sclk_fall;
  logic sclk_rise;
  logic scs_fall;
  logic scs_rise;
  logic sdi_sync;

  assign sclk_fall = sclk_sh[2] & ~sclk_sh[1];
  assign sclk_rise = ~sclk_sh[2] & sclk_sh[1];
  assign scs_fall  = scs_sh[2] & ~scs_sh[1];
  assign scs_rise  = ~scs_sh[2] & scs_sh[1];
  assign sdi_sync  = sdi_sh[1];

  // ---------------------------------------------------------------------------
  // Input snapshot, taken when attention falls. The reply is built only from
  // these registers so a frame is self-consistent even if inputs move mid-poll.
  // ---------------------------------------------------------------------------
  logic [15:0] snap_buttons;
  logic [7:0]  snap_rx;
  logic [7:0]  snap_ry;
  logic [7:0]  snap_lx;
  logic [7:0]  snap_ly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_buttons <= 16'h0000;
      snap_rx      <= 8'h80;
      snap_ry      <= 8'h80;
      snap_lx      <= 8'h80;
      snap_ly      <= 8'h80;
    end else if (scs_fall) begin
      snap_buttons <= buttons;
      snap_rx      <= rx;
      snap_ry      <= ry;
      snap_lx      <= lx;
      snap_ly      <= ly;
    end
  end

  // ---------------------------------------------------------------------------
  // Reply byte for the current byte index. Buttons go out active-low.
  // ---------------------------------------------------------------------------
  logic [7:0] reply_byte;

  always_comb begin
    reply_byte = 8'hFF;
    case (byte_idx)
      4'd0:    reply_byte = 8'hFF;
      4'd1:    reply_byte = PAD_ID;
      4'd2:    reply_byte = 8'h5A;
      4'd3:    reply_byte = ~snap_buttons[7:0];
      4'd4:    reply_byte = ~snap_buttons[15:8];
      4'd5:    reply_byte = snap_rx;
      4'd6:    reply_byte = snap_ry;
      4'd7:    reply_byte = snap_lx;
      4'd8:    reply_byte = snap_ly;
      default: reply_byte = 8'hFF;
    endcase
  end

  // Command byte as it will look once the current bit is shifted in; the
  // header check is made on this value in the same cycle as bit 7 arrives.
  logic [7:0] cmd_next;
  logic       header_bad;

  assign cmd_next   = {sdi_sync, cmd[7:1]};
  assign header_bad = ((byte_idx == 4'd0) && (cmd_next != 8'h01)) ||
                      ((byte_idx == 4'd1) && (cmd_next != 8'h42));

  // ---------------------------------------------------------------------------
  // Transaction FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sdo      <= 1'b1;
      ack      <= 1'b1;
      busy     <= 1'b0;
      polled   <= 1'b0;
      bit_idx  <= 3'd0;
      byte_idx <= 4'd0;
      cmd      <= 8'h00;
      timer    <= '0;
    end else begin
      polled <= 1'b0;
      if (scs_rise) begin
        // Master released attention: abandon whatever was in flight.
        state <= IDLE;
        sdo   <= 1'b1;
        ack   <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sdo  <= 1'b1;
            ack  <= 1'b1;
            busy <= 1'b0;
            if (scs_fall) begin
              state    <= SHIFT;
              byte_idx <= 4'd0;
              bit_idx  <= 3'd0;
              busy     <= 1'b1;
            end
          end

          SHIFT: begin
            if (sclk_fall) begin
              sdo <= reply_byte[bit_idx];
            end else if (sclk_rise) begin
              cmd <= cmd_next;
              if (bit_idx == 3'd7) begin
                if (header_bad) begin
                  // Not a poll addressed to us: stay quiet until released.
                  state <= HOLD;
                  sdo   <= 1'b1;
                end else if (byte_idx == LAST_BYTE) begin
                  // Last byte carries no ack.
                  state  <= HOLD;
                  sdo    <= 1'b1;
                  polled <= 1'b1;
                end else begin
                  state <= ACK_WAIT;
                  timer <= '0;
                end
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end

          ACK_WAIT: begin
            if (timer == DELAY_END) begin
              state <= ACK;
              ack   <= 1'b0;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end

          ACK: begin
            if (timer == WIDTH_END) begin
              state    <= SHIFT;
              ack      <= 1'b1;
              byte_idx <= byte_idx + 4'd1;
              bit_idx  <= 3'd0;
              timer    <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end

          HOLD: begin
            sdo <= 1'b1;
            ack <= 1'b1;
          end

          default: begin
            state <= IDLE;
            sdo   <= 1'b1;
            ack   <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_pad_responder.sv
// tb_ps2_pad_responder: drives PS2 polls into an analog and a digital responder.
// Expected reply bytes, ack counts and pin states are queued by the stimulus;
// a single checker process compares them as the DUTs present them.
`timescale 1ns/1ps

module tb_ps2_pad_responder;

  localparam int ACK_DELAY = 40;
  localparam int ACK_WIDTH = 80;
  localparam int H         = 6;   // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        scs_a;
  logic        scs_d;
  logic        sdi;
  logic [15:0] buttons;
  logic [7:0]  rx, ry, lx, ly;
  logic        sdo_a, ack_a, busy_a, polled_a;
  logic        sdo_d, ack_d, busy_d, polled_d;

  always #5 clk = ~clk;

  ps2_pad_responder #(.ANALOG(1'b1), .ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut_a (
    .clk(clk), .rst(rst), .sclk(sclk), .scs(scs_a), .sdi(sdi),
    .buttons(buttons), .rx(rx), .ry(ry), .lx(lx), .ly(ly),
    .sdo(sdo_a), .ack(ack_a), .busy(busy_a), .polled(polled_a)
  );

  ps2_pad_responder #(.ANALOG(1'b0), .ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut_d (
    .clk(clk), .rst(rst), .sclk(sclk), .scs(scs_d), .sdi(sdi),
    .buttons(buttons), .rx(rx), .ry(ry), .lx(lx), .ly(ly),
    .sdo(sdo_d), .ack(ack_d), .busy(busy_d), .polled(polled_d)
  );

  // kind: 0 pins {busy,sdo,ack,polled}, 1 ack count, 2 polled count,
  //       3 snapshot idle values (dut_a), 4 scoreboard drained
  typedef struct {
    int          kind;
    int          sel;
    int          tag;
    logic [31:0] val;
  } probe_t;

  logic [7:0] exp_q[$];
  probe_t     probe_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pins(input int s);
    if (s == 0) return {28'd0, busy_a, sdo_a, ack_a, polled_a};
    else        return {28'd0, busy_d, sdo_d, ack_d, polled_d};
  endfunction

  // ---------------------------------------------------------------------------
  // Checker: runs on the falling clk edge, away from DUT updates and from the
  // stimulus, which changes pins 2 ns after the rising edge.
  // ---------------------------------------------------------------------------
  logic       sclk_p  = 1'b1;
  logic       scs_a_p = 1'b1;
  logic       scs_d_p = 1'b1;
  logic [1:0] ack_p   = 2'b11;
  int         mbits   = 0;
  logic [7:0] mbyte   = 8'h00;
  int         last_rise = 0;
  int         low_start[2] = '{0, 0};
  bit         tracking[2]  = '{1'b0, 1'b0};
  int         ack_cnt[2]   = '{0, 0};
  int         pol_cnt[2]   = '{0, 0};

  always @(negedge clk) begin
    logic   a_now;
    logic   p_now;
    logic [7:0] e;
    probe_t p;

    if ((scs_a_p && !scs_a) || (scs_d_p && !scs_d)) mbits = 0;

    if (!sclk_p && sclk) begin
      last_rise = cyc;
      if (!scs_a || !scs_d) begin
        mbyte = {(!scs_a ? sdo_a : sdo_d), mbyte[7:1]};
        mbits++;
        if (mbits == 8) begin
          mbits = 0;
          if (exp_q.size() == 0) chk("byte_unexpected", {24'd0, mbyte}, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("byte", {24'd0, mbyte}, {24'd0, e});
          end
        end
      end
    end

    for (int s = 0; s < 2; s++) begin
      a_now = (s == 0) ? ack_a : ack_d;
      p_now = (s == 0) ? polled_a : polled_d;
      if (rst) begin
        tracking[s] = 1'b0;
      end else begin
        if (ack_p[s] && !a_now) begin
          chk($sformatf("ack_delay_dut%0d", s), cyc - last_rise, 3 + ACK_DELAY);
          ack_cnt[s]++;
          low_start[s] = cyc;
          tracking[s]  = 1'b1;
        end
        if (!ack_p[s] && a_now && tracking[s]) begin
          chk($sformatf("ack_width_dut%0d", s), cyc - low_start[s], ACK_WIDTH);
          tracking[s] = 1'b0;
        end
        if (p_now) begin
          chk($sformatf("polled_delay_dut%0d", s), cyc - last_rise, 3);
          pol_cnt[s]++;
        end
      end
      ack_p[s] = a_now;
    end

    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      case (p.kind)
        0: chk($sformatf("pins%0d_dut%0d", p.tag, p.sel), pins(p.sel), p.val);
        1: chk($sformatf("ack_count%0d_dut%0d", p.tag, p.sel), ack_cnt[p.sel], p.val);
        2: chk($sformatf("polled_count%0d_dut%0d", p.tag, p.sel), pol_cnt[p.sel], p.val);
        3: begin
          chk($sformatf("snap_buttons%0d", p.tag), {16'd0, dut_a.snap_buttons}, 32'h0000_0000);
          chk($sformatf("snap_sticks%0d", p.tag),
              {dut_a.snap_rx, dut_a.snap_ry, dut_a.snap_lx, dut_a.snap_ly}, 32'h8080_8080);
        end
        default: chk($sformatf("drained%0d", p.tag), exp_q.size(), 0);
      endcase
    end

    sclk_p  = sclk;
    scs_a_p = scs_a;
    scs_d_p = scs_d;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] cmd_v[9];
  logic [7:0] exp_v[9];
  int         chg_after = -1;
  int         ptag      = 0;
  int         exp_ack[2] = '{0, 0};
  int         exp_pol[2] = '{0, 0};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_probe(input int kind, input int sel, input logic [31:0] val);
    probe_t p;
    p.kind = kind; p.sel = sel; p.tag = ptag; p.val = val;
    ptag++;
    probe_q.push_back(p);
  endtask

  task automatic push_counts;
    for (int s = 0; s < 2; s++) begin
      push_probe(1, s, exp_ack[s]);
      push_probe(2, s, exp_pol[s]);
    end
  endtask

  task automatic set_scs(input int sel, input logic v);
    if (sel == 0) scs_a = v; else scs_d = v;
  endtask

  task automatic xfer(input logic [7:0] c, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      sdi  = c[i];
      tick(H);
      sclk = 1'b1;
      tick(H);
    end
  endtask

  // Master side of the handshake: bounded wait for ack low, then release.
  task automatic wait_ack(input int sel);
    for (int t = 0; t < ACK_DELAY + 20; t++) begin
      if (((sel == 0) ? ack_a : ack_d) == 1'b0) break;
      tick(1);
    end
    for (int t = 0; t < ACK_WIDTH + 20; t++) begin
      if (((sel == 0) ? ack_a : ack_d) == 1'b1) break;
      tick(1);
    end
    tick(1);
  endtask

  // One poll: busy timing on entry, nsend bytes, acks waited for bytes
  // below ack_upto, HOLD state before release and IDLE state after.
  task automatic run_frame(input int sel, input int nsend, input int ack_upto);
    set_scs(sel, 1'b0);
    tick(2);
    push_probe(0, sel, 32'b0110);
    tick(1);
    push_probe(0, sel, 32'b1110);
    tick(5);
    for (int b = 0; b < nsend; b++) begin
      exp_q.push_back(exp_v[b]);
      xfer(cmd_v[b], 8);
      if (b == chg_after) begin
        buttons = 16'hFFFF; rx = 8'h00; ry = 8'h00; lx = 8'h00; ly = 8'h00;
      end
      if (b < ack_upto) wait_ack(sel);
    end
    tick(4);
    push_probe(0, sel, 32'b1110);
    set_scs(sel, 1'b1);
    tick(3);
    push_probe(0, sel, 32'b0110);
    tick(5);
  endtask

  task automatic load_test1;
    buttons = 16'h0010; rx = 8'h11; ry = 8'h22; lx = 8'h33; ly = 8'h44;
    cmd_v = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_v = '{8'hFF, 8'h73, 8'h5A, 8'hEF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b1; scs_a = 1'b1; scs_d = 1'b1; sdi = 1'b1;
    buttons = 16'h1234; rx = 8'h01; ry = 8'h02; lx = 8'h03; ly = 8'h04;
    tick(2);
    push_probe(0, 0, 32'b0110);
    push_probe(0, 1, 32'b0110);
    push_probe(3, 0, 32'd0);
    tick(3);
    rst = 1'b0;
    tick(5);

    // Analog poll, full frame.
    load_test1();
    run_frame(0, 9, 8);
    exp_ack[0] += 8; exp_pol[0] += 1;
    push_counts();

    // Digital poll, all buttons pressed.
    buttons = 16'hFFFF;
    cmd_v = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_v = '{8'hFF, 8'h41, 8'h5A, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame(1, 5, 4);
    exp_ack[1] += 4; exp_pol[1] += 1;
    push_counts();

    // Bad first header byte: no ack, sdo held high.
    cmd_v[0] = 8'h81;
    exp_v = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame(0, 2, 0);
    push_counts();

    // Bad second header byte: ID is still sent, then silence.
    cmd_v = '{8'h01, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_v = '{8'hFF, 8'h73, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame(0, 3, 1);
    exp_ack[0] += 1;
    push_counts();

    // Abort after bit 3 of byte 4 while sdo is low (0xF7 bit 3 = 0).
    buttons = 16'h0800; rx = 8'h80; ry = 8'h80; lx = 8'h80; ly = 8'h80;
    cmd_v = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_v = '{8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hF7, 8'h80, 8'h80, 8'h80, 8'h80};
    scs_a = 1'b0;
    tick(8);
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(exp_v[b]);
      xfer(cmd_v[b], 8);
      wait_ack(0);
    end
    xfer(8'h00, 4);
    scs_a = 1'b1;
    tick(2);
    push_probe(0, 0, 32'b1010);
    tick(1);
    push_probe(0, 0, 32'b0110);
    tick(5);
    exp_ack[0] += 4;
    push_counts();
    load_test1();
    run_frame(0, 9, 8);
    exp_ack[0] += 8; exp_pol[0] += 1;
    push_counts();

    // Inputs change mid-frame; reply keeps the snapshot.
    buttons = 16'h0000; rx = 8'h80; ry = 8'h80; lx = 8'h80; ly = 8'h80;
    exp_v = '{8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80};
    chg_after = 2;
    run_frame(0, 9, 8);
    chg_after = -1;
    exp_ack[0] += 8; exp_pol[0] += 1;
    push_counts();

    // Reset while ack is low.
    load_test1();
    scs_a = 1'b0;
    tick(8);
    exp_q.push_back(8'hFF);
    xfer(8'h01, 8);
    for (int t = 0; t < ACK_DELAY + 20; t++) begin
      if (!ack_a) break;
      tick(1);
    end
    tick(20);
    rst = 1'b1;
    push_probe(0, 0, 32'b0110);
    tick(1);
    scs_a = 1'b1;
    tick(4);
    push_probe(3, 0, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(5);
    exp_ack[0] += 1;
    push_counts();

    // Recovery: a clean poll after reset.
    load_test1();
    run_frame(0, 9, 8);
    exp_ack[0] += 8; exp_pol[0] += 1;
    push_counts();

    tick(5);
    push_probe(4, 0, 32'd0);
    for (int t = 0; t < 100 && probe_q.size() > 0; t++) tick(1);
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
